// File: rtl/dcc_adc_capture.sv
// dcc_adc_capture: triggered ADC snapshot buffer with streaming readout.
//
// Arm, optionally wait for a rising level crossing, capture a block of
// samples into an internal RAM, then stream them out. The out-of-range
// counter is built only when DCC_CAP_OR_CNT_EN is defined; otherwise
// OR_CNT reads as zero.
//
// Readout handshake: a word moves when RD_VALID and RD_READY are both high
// on a rising CLK edge. Once RD_VALID is high, RD_DATA, RD_VALID and
// RD_LAST stay unchanged until that transfer happens. Only ABORT or RST can
// withdraw RD_VALID early. RD_READY may be driven high at any time.
module dcc_adc_capture #(
  parameter int DW = 14,
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] ADC_D,
  input  logic          ADC_OR,
  input  logic          ARM,
  input  logic          ABORT,
  input  logic          TRIG_MODE,
  input  logic [DW-1:0] TRIG_LEVEL,
  input  logic [AW:0]   CAP_LEN,
  output logic [DW-1:0] RD_DATA,
  output logic          RD_VALID,
  input  logic          RD_READY,
  output logic          RD_LAST,
  output logic          BUSY,
  output logic          DONE,
  output logic [15:0]   OR_CNT,
  output logic [1:0]    DBG_STATE
);

  localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    READOUT   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] mem [2**AW];

  logic [DW-1:0] cur_d, prev_d;
  logic          mode_q;
  logic [DW-1:0] level_q;
  logic [AW:0]   len_q;
  logic [AW:0]   wr_cnt;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q, rd_last_q, done_q;
  logic          first_q;

  logic          wr_en, ld_rd, done_set, arm_acc;
  logic [AW:0]   len_eff;

  // Zero or oversize lengths mean a full buffer.
  assign len_eff = ((CAP_LEN == '0) || (CAP_LEN > DEPTH_W)) ? DEPTH_W : CAP_LEN;

  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_LAST   = rd_last_q;
  assign DONE      = done_q;
  assign BUSY      = (state != IDLE);
  assign DBG_STATE = state;

  // State register; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and per-cycle datapath strobes; ABORT overrides all of them.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    ld_rd      = 1'b0;
    done_set   = 1'b0;
    arm_acc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ARM) begin
          arm_acc    = 1'b1;
          state_next = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (!mode_q) begin
          state_next = CAPTURE;
        end else if (!first_q && (prev_d < level_q) && (cur_d >= level_q)) begin
          // The crossing sample itself becomes word 0.
          wr_en      = 1'b1;
          state_next = (len_q == ONE_W) ? READOUT : CAPTURE;
        end
      end
      CAPTURE: begin
        wr_en = 1'b1;
        if ((wr_cnt + 1'b1) == len_q) state_next = READOUT;
      end
      READOUT: begin
        if (!rd_valid_q || RD_READY) begin
          if (rd_valid_q && rd_last_q) begin
            done_set   = 1'b1;
            state_next = IDLE;
          end else begin
            ld_rd = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (ABORT) begin
      state_next = IDLE;
      wr_en      = 1'b0;
      ld_rd      = 1'b0;
      done_set   = 1'b0;
      arm_acc    = 1'b0;
    end
  end

  // Sample buffer write port; contents survive reset and abort.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_cnt[AW-1:0]] <= cur_d;
  end

  // Input stage, armed settings, write counter and readout register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_d      <= '0;
      prev_d     <= '0;
      mode_q     <= 1'b0;
      level_q    <= '0;
      len_q      <= '0;
      wr_cnt     <= '0;
      rd_ptr     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      cur_d   <= ADC_D;
      prev_d  <= cur_d;
      done_q  <= done_set;
      // High only during the first WAIT_TRIG cycle, while prev is not yet trusted.
      first_q <= arm_acc;
      if (arm_acc) begin
        mode_q  <= TRIG_MODE;
        level_q <= TRIG_LEVEL;
        len_q   <= len_eff;
        wr_cnt  <= '0;
        rd_ptr  <= '0;
      end
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (ld_rd) begin
        rd_data_q  <= mem[rd_ptr];
        rd_valid_q <= 1'b1;
        rd_last_q  <= ({1'b0, rd_ptr} == (len_q - 1'b1));
        rd_ptr     <= rd_ptr + 1'b1;
      end
      if (done_set || ABORT) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
    end
  end

`ifdef DCC_CAP_OR_CNT_EN
  logic        cur_or;
  logic [15:0] or_cnt_q;

  // Out-of-range count over stored samples, saturating at all ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_or   <= 1'b0;
      or_cnt_q <= '0;
    end else begin
      cur_or <= ADC_OR;
      if (arm_acc)
        or_cnt_q <= '0;
      else if (wr_en && cur_or && (or_cnt_q != 16'hFFFF))
        or_cnt_q <= or_cnt_q + 16'd1;
    end
  end

  assign OR_CNT = or_cnt_q;
`else
  logic or_unused;
  assign or_unused = ADC_OR;
  assign OR_CNT    = '0;
`endif

endmodule

// File: tb/tb_dcc_adc_capture.sv
// Directed bench for dcc_adc_capture: table of capture/readout scenarios
// plus hand sequences for stuck trigger, abort, OR counting and reset.
module tb_dcc_adc_capture;

  logic        CLK = 1'b0;
  logic        RST;
  logic [13:0] ADC_D;
  logic        ADC_OR;
  logic        ARM, ABORT, TRIG_MODE;
  logic [13:0] TRIG_LEVEL;
  logic [10:0] CAP_LEN;
  logic [13:0] RD_DATA;
  logic        RD_VALID, RD_READY, RD_LAST, BUSY, DONE;
  logic [15:0] OR_CNT;
  logic [1:0]  DBG_STATE;

  int checks = 0;
  int errors = 0;

  logic [13:0] adc_val;
  logic        ramp_on;
  logic        or_en;

  dcc_adc_capture dut (
    .CLK(CLK), .RST(RST), .ADC_D(ADC_D), .ADC_OR(ADC_OR), .ARM(ARM),
    .ABORT(ABORT), .TRIG_MODE(TRIG_MODE), .TRIG_LEVEL(TRIG_LEVEL),
    .CAP_LEN(CAP_LEN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .RD_READY(RD_READY), .RD_LAST(RD_LAST), .BUSY(BUSY), .DONE(DONE),
    .OR_CNT(OR_CNT), .DBG_STATE(DBG_STATE)
  );

  // Clock
  always #5 CLK = ~CLK;

  typedef struct {
    logic        mode;
    logic [13:0] level;
    logic [10:0] len;
    logic [3:0]  ready_pat;
    logic [13:0] start;
    logic [13:0] exp_first;
    int          exp_n;
  } row_t;

  row_t rows [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic or_hit(input logic [13:0] v);
    return (v == 14'd400) || (v == 14'd403) || (v == 14'd408) ||
           (v == 14'd416) || (v == 14'd417);
  endfunction

  // One clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
    if (ramp_on) adc_val = adc_val + 14'd1;
    ADC_D  = adc_val;
    ADC_OR = or_en && or_hit(adc_val);
  endtask

  task automatic run_row(input row_t r, input int k);
    int          n_rx, done_cnt, post;
    logic        got_last, stall;
    logic [13:0] hold_d;
    logic        hold_l;
    logic [13:0] exp_d;
    adc_val    = r.start;
    ADC_D      = adc_val;
    ADC_OR     = 1'b0;
    ARM        = 1'b1;
    TRIG_MODE  = r.mode;
    TRIG_LEVEL = r.level;
    CAP_LEN    = r.len;
    RD_READY   = 1'b0;
    step();
    ARM = 1'b0;
    n_rx = 0; done_cnt = 0; post = 0; got_last = 1'b0; stall = 1'b0;
    hold_d = '0; hold_l = 1'b0;
    for (int c = 0; c < 3000 && post < 3; c++) begin
      RD_READY = r.ready_pat[3 - (c % 4)];
      if (DONE) done_cnt++;
      if (got_last) post++;
      if (stall) begin
        check($sformatf("row%0d_stall_valid", k), RD_VALID, 1'b1);
        check($sformatf("row%0d_stall_data", k), RD_DATA, hold_d);
        check($sformatf("row%0d_stall_last", k), RD_LAST, hold_l);
      end
      if (RD_VALID && RD_READY && !got_last) begin
        exp_d = r.exp_first + n_rx[13:0];
        check($sformatf("row%0d_data%0d", k, n_rx), RD_DATA, exp_d);
        check($sformatf("row%0d_last%0d", k, n_rx), RD_LAST, (n_rx == r.exp_n - 1));
        n_rx++;
        if (RD_LAST) got_last = 1'b1;
      end
      stall  = RD_VALID && !RD_READY;
      hold_d = RD_DATA;
      hold_l = RD_LAST;
      step();
    end
    check($sformatf("row%0d_count", k), n_rx, r.exp_n);
    check($sformatf("row%0d_got_last", k), got_last, 1'b1);
    check($sformatf("row%0d_done_pulses", k), done_cnt, 1);
    check($sformatf("row%0d_idle_busy", k), BUSY, 1'b0);
  endtask

  initial begin
    logic ok;
    rows[0] = '{1'b0, 14'h0,    11'd4,    4'b1111, 14'd100,   14'd101,   4};
    rows[1] = '{1'b0, 14'h0,    11'd8,    4'b1001, 14'd200,   14'd201,   8};
    rows[2] = '{1'b0, 14'h0,    11'd0,    4'b1111, 14'd0,     14'd1,     1024};
    rows[3] = '{1'b0, 14'h0,    11'd1,    4'b1111, 14'd50,    14'd51,    1};
    rows[4] = '{1'b0, 14'h0,    11'd1500, 4'b1111, 14'd300,   14'd301,   1024};
    rows[5] = '{1'b1, 14'h2000, 11'd2,    4'b1111, 14'h1FFE,  14'h2000,  2};
    rows[6] = '{1'b1, 14'h0100, 11'd3,    4'b0101, 14'h00F0,  14'h0100,  3};

    // Reset
    RST = 1'b1; ARM = 1'b0; ABORT = 1'b0; TRIG_MODE = 1'b0; TRIG_LEVEL = '0;
    CAP_LEN = '0; RD_READY = 1'b1; adc_val = 14'h1234; ADC_D = adc_val; ADC_OR = 1'b1;
    ramp_on = 1'b0; or_en = 1'b0;
    ARM = 1'b1; ABORT = 1'b1;
    step(); step(); step();
    check("rst_busy", BUSY, 1'b0);
    check("rst_valid", RD_VALID, 1'b0);
    check("rst_last", RD_LAST, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_or_cnt", OR_CNT, 16'd0);
    check("rst_data", RD_DATA, 14'd0);
    check("rst_state", DBG_STATE, 2'd0);
    RST = 1'b0; ARM = 1'b0; ABORT = 1'b0; ADC_OR = 1'b0;
    step();

    // Table-driven capture/readout scenarios
    ramp_on = 1'b1;
    for (int k = 0; k < 7; k++) run_row(rows[k], k);

    // Trigger that never crosses: held above level, then abort
    ramp_on = 1'b0;
    adc_val = 14'h0200; ADC_D = adc_val;
    TRIG_MODE = 1'b1; TRIG_LEVEL = 14'h0100; CAP_LEN = 11'd4; ARM = 1'b1;
    step();
    ARM = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("stuck_busy", BUSY, 1'b1);
    check("stuck_state", DBG_STATE, 2'd1);
    TRIG_MODE = 1'b0; ARM = 1'b1;
    step();
    ARM = 1'b0;
    step(); step();
    check("rearm_ignored_state", DBG_STATE, 2'd1);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    check("abort_busy", BUSY, 1'b0);
    check("abort_done", DONE, 1'b0);
    check("abort_valid", RD_VALID, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (DONE || BUSY) ok = 1'b0;
    end
    check("abort_no_done_after", ok, 1'b1);

    // ABORT together with ARM
    ARM = 1'b1; ABORT = 1'b1;
    step();
    ARM = 1'b0; ABORT = 1'b0;
    check("arm_abort_busy", BUSY, 1'b0);
    step();
    check("arm_abort_busy2", BUSY, 1'b0);

    // OR counting over 16 samples, then reset in the middle of readout
    ramp_on = 1'b1; or_en = 1'b1;
    adc_val = 14'd400; ADC_D = adc_val; ADC_OR = or_hit(adc_val);
    TRIG_MODE = 1'b0; CAP_LEN = 11'd16; RD_READY = 1'b0; ARM = 1'b1;
    step();
    ARM = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (RD_VALID) ok = 1'b1;
      else step();
    end
    check("or_readout_valid", ok, 1'b1);
`ifdef DCC_CAP_OR_CNT_EN
    check("or_cnt", OR_CNT, 16'd3);
`else
    check("or_cnt", OR_CNT, 16'd0);
`endif
    check("or_first_word", RD_DATA, 14'd401);
    RD_READY = 1'b1;
    step(); step(); step();
    check("or_fourth_word", RD_DATA, 14'd404);
    check("or_mid_valid", RD_VALID, 1'b1);
    RST = 1'b1; RD_READY = 1'b0;
    step();
    check("midrst_valid", RD_VALID, 1'b0);
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_data", RD_DATA, 14'd0);
    check("midrst_or_cnt", OR_CNT, 16'd0);
    check("midrst_done", DONE, 1'b0);
    RST = 1'b0; or_en = 1'b0;
    step(); step();
    check("post_rst_state", DBG_STATE, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
